// File: rtl/rs_entry_tracker.sv
// 16-slot reservation-station tracker: dual dispatch, dual CDB wakeup, dual grant free; state lands one edge after inputs.
// Dispatch beyond free space is dropped and flagged in ovf_err; RS_WAKEUP_BYPASS_EN adds zero-cycle CDB wakeup to ready_vec.
module rs_entry_tracker (
  input  logic        clock,
  input  logic        reset,
  input  logic        disp1_en,
  input  logic [5:0]  disp1_tag1,
  input  logic [5:0]  disp1_tag2,
  input  logic        disp1_rdy1,
  input  logic        disp1_rdy2,
  input  logic        disp2_en,
  input  logic [5:0]  disp2_tag1,
  input  logic [5:0]  disp2_tag2,
  input  logic        disp2_rdy1,
  input  logic        disp2_rdy2,
  input  logic        cdb1_en,
  input  logic [5:0]  cdb1_tag,
  input  logic        cdb2_en,
  input  logic [5:0]  cdb2_tag,
  input  logic [3:0]  issue1,
  input  logic [3:0]  issue2,
  input  logic        issue1_en,
  input  logic        issue2_en,
  output logic [15:0] ready_vec,
  output logic [3:0]  alloc1,
  output logic [3:0]  alloc2,
  output logic [4:0]  free_cnt,
  output logic        stall,
  output logic        ovf_err
);

  logic [15:0] valid, rdy1, rdy2;
  logic [5:0]  tag1 [16];
  logic [5:0]  tag2 [16];
  logic [15:0] hit1, hit2, freed;
  logic        acc1, acc2, drop;
  logic        g1, g2, g2_new, bad_grant;
  logic [3:0]  slot2;
  logic        d1_r1, d1_r2, d2_r1, d2_r2;
  logic [4:0]  free_nxt;

  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int i = 0; i < 16; i++) begin
      hit1[i] = (cdb1_en && cdb1_tag == tag1[i]) || (cdb2_en && cdb2_tag == tag1[i]);
      hit2[i] = (cdb1_en && cdb1_tag == tag2[i]) || (cdb2_en && cdb2_tag == tag2[i]);
    end
  end

`ifdef RS_WAKEUP_BYPASS_EN
  assign ready_vec = valid & (rdy1 | hit1) & (rdy2 | hit2);
`else
  assign ready_vec = valid & rdy1 & rdy2;
`endif

  // Port 1 takes the lowest free slot, port 2 the highest, so they never collide while two are free.
  always_comb begin
    alloc1 = '0;
    alloc2 = '0;
    for (int i = 15; i >= 0; i--)
      if (!valid[i]) alloc1 = 4'(i);
    for (int i = 0; i < 16; i++)
      if (!valid[i]) alloc2 = 4'(i);
  end

  assign stall = (free_cnt < 5'd2);

  always_comb begin
    acc1  = disp1_en && (free_cnt != 5'd0);
    acc2  = disp2_en && ((free_cnt >= 5'd2) || (free_cnt == 5'd1 && !disp1_en));
    slot2 = (free_cnt >= 5'd2) ? alloc2 : alloc1;
    drop  = (disp1_en && !acc1) || (disp2_en && !acc2);

    d1_r1 = disp1_rdy1 || (cdb1_en && cdb1_tag == disp1_tag1) || (cdb2_en && cdb2_tag == disp1_tag1);
    d1_r2 = disp1_rdy2 || (cdb1_en && cdb1_tag == disp1_tag2) || (cdb2_en && cdb2_tag == disp1_tag2);
    d2_r1 = disp2_rdy1 || (cdb1_en && cdb1_tag == disp2_tag1) || (cdb2_en && cdb2_tag == disp2_tag1);
    d2_r2 = disp2_rdy2 || (cdb1_en && cdb1_tag == disp2_tag2) || (cdb2_en && cdb2_tag == disp2_tag2);

    // A grant only counts against a ready slot; a duplicate grant frees the slot once.
    g1        = issue1_en && ready_vec[issue1];
    g2        = issue2_en && ready_vec[issue2];
    g2_new    = g2 && !(g1 && issue1 == issue2);
    bad_grant = (issue1_en && !ready_vec[issue1]) || (issue2_en && !ready_vec[issue2]);
    freed     = '0;
    if (g1) freed[issue1] = 1'b1;
    if (g2) freed[issue2] = 1'b1;

    free_nxt = free_cnt - 5'(acc1) - 5'(acc2) + 5'(g1) + 5'(g2_new);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid    <= '0;
      rdy1     <= '0;
      rdy2     <= '0;
      ovf_err  <= 1'b0;
      free_cnt <= 5'd16;
      for (int i = 0; i < 16; i++) begin
        tag1[i] <= '0;
        tag2[i] <= '0;
      end
    end else begin
      // Free wins over a same-cycle wakeup on the granted slot.
      for (int i = 0; i < 16; i++) begin
        if (freed[i]) begin
          valid[i] <= 1'b0;
          rdy1[i]  <= 1'b0;
          rdy2[i]  <= 1'b0;
        end else if (valid[i]) begin
          if (hit1[i]) rdy1[i] <= 1'b1;
          if (hit2[i]) rdy2[i] <= 1'b1;
        end
      end
      if (acc1) begin
        valid[alloc1] <= 1'b1;
        tag1[alloc1]  <= disp1_tag1;
        tag2[alloc1]  <= disp1_tag2;
        rdy1[alloc1]  <= d1_r1;
        rdy2[alloc1]  <= d1_r2;
      end
      if (acc2) begin
        valid[slot2] <= 1'b1;
        tag1[slot2]  <= disp2_tag1;
        tag2[slot2]  <= disp2_tag2;
        rdy1[slot2]  <= d2_r1;
        rdy2[slot2]  <= d2_r2;
      end
      free_cnt <= free_nxt;
      if (drop || bad_grant) ovf_err <= 1'b1;
    end
  end

endmodule

// File: doc/rs_entry_tracker.md
RS_ENTRY_TRACKER -- requirements
Module: rs_entry_tracker

Interface
REQ-001 clock  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 disp1_en, disp2_en  input  1 each  dispatch request, ports 1 and 2.
REQ-004 dispN_tag1, dispN_tag2  input  6 each  source physical-register tags for port N.
REQ-005 dispN_rdy1, dispN_rdy2  input  1 each  source operand already available at dispatch.
REQ-006 cdb1_en, cdb2_en  input  1 each  CDB broadcast valid.
REQ-007 cdb1_tag, cdb2_tag  input  6 each  broadcast result tag.
REQ-008 issue1, issue2  input  4 each  grant slot indices returned by the issue selector.
REQ-009 issue1_en, issue2_en  input  1 each  grant valid.
REQ-010 ready_vec  output  16  per-slot issue-ready; drives the selector request vector.
REQ-011 alloc1, alloc2  output  4 each  slots written by dispatch ports 1/2 this cycle.
REQ-012 free_cnt  output  5  free slots, 0..16.
REQ-013 stall  output  1  high when free_cnt < 2.
REQ-014 ovf_err  output  1  sticky protocol-error flag.

Function
REQ-015 Per-slot state SHALL be valid, tag1, tag2, rdy1, rdy2; 16 slots.
REQ-016 ready_vec[i] SHALL be valid & rdy1 & rdy2, from registered state.
REQ-017 alloc1 SHALL be the lowest-index free slot; alloc2 the highest-index free slot; both combinational from current state.
REQ-018 Accepted dispatch SHALL write tags/rdy bits and set valid at the next edge; ready_vec reflects it one cycle later at the earliest.
REQ-019 free_cnt >= 2: both ports accepted into alloc1/alloc2 (distinct).
REQ-020 free_cnt == 1: port 1 accepted; port 2 dropped. If only disp2_en is asserted, port 2 SHALL use alloc1.
REQ-021 free_cnt == 0: all dispatch dropped.
REQ-022 Any dropped dispatch SHALL set ovf_err.
REQ-023 Granted valid slot SHALL clear valid at the next edge; the slot is allocatable from the following cycle, never the same cycle.
REQ-024 issue1 == issue2 with both enables SHALL free the slot once; free_cnt rises by 1.
REQ-025 Grant to an invalid slot, or to a slot with ready_vec bit 0, SHALL be ignored and SHALL set ovf_err.
REQ-026 CDB wakeup: each valid slot SHALL set rdyK at the next edge when tagK equals an enabled cdb tag; both CDBs are checked in parallel.
REQ-027 Dispatch-time wakeup: an operand whose dispatched tag matches an enabled cdb tag in the same cycle SHALL be stored ready.
REQ-028 When a grant and a wakeup hit the same slot, the free SHALL take priority.
REQ-029 free_cnt SHALL be updated as previous value minus accepted dispatches plus distinct valid grants; it SHALL never wrap.

Reset
REQ-030 On reset, all valid/rdy bits, ovf_err and free_cnt SHALL take reset values: valid/rdy = 0, ovf_err = 0, free_cnt = 16.
REQ-031 Reset values of the remaining outputs SHALL be: ready_vec = 0, alloc1 = 0, alloc2 = 15, stall = 0.
REQ-032 Reset SHALL override same-cycle dispatch, grant and CDB inputs; in-flight entries are discarded.

Configuration
REQ-033 With RS_WAKEUP_BYPASS_EN defined, ready_vec[i] SHALL also assert combinationally in the CDB cycle when the last missing operand matches an enabled cdb tag (zero-cycle wakeup).
REQ-034 Without RS_WAKEUP_BYPASS_EN, ready_vec SHALL come from registered state only, asserting one cycle after the matching CDB.

Verification
REQ-035 After reset, dispatch both ports with all rdy=1 -> alloc1=0, alloc2=15; next cycle ready_vec=16'h8001, free_cnt=14.
REQ-036 Fill to 15 entries, dispatch both ports -> port 1 accepted, port 2 dropped, free_cnt=0, ovf_err=1, stall=1.
REQ-037 Slot 3 waiting on tag 6'd9, cdb2 broadcasts 9 in cycle N -> ready_vec[3]=1 in cycle N+1 (no macro), or in cycle N (macro defined).
REQ-038 Grant issue1=issue2=5, both enables asserted, slot valid and ready -> slot 5 freed once; free_cnt +1; ready_vec[5]=0 next cycle.
REQ-039 Dispatch with tag1=12 while cdb1 broadcasts 12 in the same cycle -> entry stored with rdy1=1; ready_vec bit set next cycle if rdy2=1.
REQ-040 Assert reset mid-operation with 8 valid entries -> next cycle ready_vec=0, free_cnt=16, ovf_err=0.
